icache_axi_rd_bridge: RTL and testbench
=======================================

// Module: icache_axi_rd_bridge
// PURPOSE
//  Bus-side responder for the I-cache refill port: accepts one cache-line read (rd_req/rd_addr),
//  issues a single AXI4 INCR read burst, and streams the beats back as ret_valid/ret_last/ret_data.
//  Sits between the I-cache miss logic and the AXI crossbar; one outstanding request at a time.
// PARAMETERS
//  ADDR_W   32  address width (cache and AR channel)
//  DATA_W   64  beat width; arsize = log2(DATA_W/8)
//  BEATS    2   beats per line (power of 2, >=2); arlen = BEATS-1; line = BEATS*DATA_W/8 bytes
//  AXI_ID   0   constant arid value (4 bits)
// PORTS
//  clock      in   1       clock
//  reset      in   1       reset, synchronous, active-high
//  rd_req     in   1       cache read request, may be a 1-cycle pulse; sampled only when rd_rdy=1
//  rd_addr    in   ADDR_W  line address from cache
//  rd_rdy     out  1       bridge idle, can accept rd_req
//  ret_valid  out  1       returned beat valid (1 cycle per beat)
//  ret_last   out  1       final beat of the line
//  ret_data   out  DATA_W  returned beat data
//  arvalid    out  1       AXI AR valid
//  arready    in   1       AXI AR ready
//  araddr     out  ADDR_W  AXI AR address
//  arid/arlen/arsize/arburst  out 4/8/3/2  AXI_ID / BEATS-1 / log2(DATA_W/8) / 2'b01 (INCR)
//  rvalid     in   1       AXI R valid
//  rready     out  1       AXI R ready
//  rdata      in   DATA_W  AXI R data
//  rresp      in   2       AXI R response
//  rlast      in   1       AXI R last
// BEHAVIOUR
//  - States: IDLE -> AR -> R -> IDLE. rd_rdy = (state==IDLE), combinational.
//  - Reset: state IDLE; arvalid=0, araddr=0, rready=0, ret_valid=0, ret_last=0, ret_data=0,
//    beat cnt=0; rd_rdy=1. Reset mid-burst aborts immediately (arvalid/rready drop same edge).
//  - IDLE: rd_req=1 at edge N -> araddr <= rd_addr with low log2(BEATS*DATA_W/8) bits cleared,
//    arvalid=1 from cycle N+1, state AR. rd_req=0 -> stay.
//  - AR: hold arvalid/araddr stable until arvalid&arready; on that edge arvalid<=0, rready<=1, cnt<=0, state R.
//  - R: on each rvalid&rready edge K: ret_data<=rdata, ret_valid<=1 in cycle K+1 (1-cycle pulse),
//    cnt<=cnt+1; ret_last<=1 iff cnt==BEATS-1. On final beat: rready<=0, state IDLE
//    (rd_rdy=1 in same cycle as ret_last=1).
//  - ret_valid/ret_last cleared every cycle without a beat handshake. No backpressure from cache.
//  - Framing decided by beat counter only; rlast, rid and rresp do not alter ret_* or state.
//  - rd_req while rd_rdy=0 is ignored (requester must not issue).
//  - Min latency rd_req edge N to first ret_valid: N+3 (arready=1 at N+1, rvalid=1 at N+2).
//  - Beat counter width log2(BEATS); wraps to 0 after final beat.
// CONFIGURATION
//  ICACHE_AXI_RD_ERR_EN defined: adds output rd_err (1 bit, reset 0), sticky set on any R
//  handshake with rresp!=2'b00 or rlast mismatching (cnt==BEATS-1); cleared only by reset.
//  Not defined: port absent, rresp/rlast fully ignored.
// TESTING
//  1 reset, rd_req=0 -> rd_rdy=1, arvalid=0, rready=0, ret_valid=0 for 10 cycles.
//  2 rd_addr=0x8000_1238, arready=1, rvalid=1 with 0x11..,0x22.. -> araddr=0x8000_1230, arlen=1,
//    arsize=3, arburst=1; ret_valid 2 cycles: 0x11.. (last=0) then 0x22.. (last=1); rd_rdy=1 after.
//  3 arready held 0 for 5 cycles -> arvalid/araddr stable, rd_rdy=0, no ret_valid until accepted.
//  4 rvalid gaps (beat, 3 idle, beat) -> ret_valid only after each handshake, last on 2nd beat.
//  5 reset asserted in R after beat 0 -> next cycle state IDLE, rready=0, ret_valid=0; new
//    request then completes normally.
//  6 [ERR_EN] rresp=2'b10 on beat 1 -> rd_err=1 and stays 1; ret data/last unchanged; without macro no rd_err.

Source files
------------

// File: rtl/icache_axi_rd_bridge_if.sv
// Bundle of the I-cache refill port and the AXI4 AR/R channels seen by the bridge.
// Purely wiring: no logic, no latency.
// master = bridge side, slave = cache/AXI environment side; rd_err exists only with ICACHE_AXI_RD_ERR_EN.
interface icache_axi_rd_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // cache request side
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    // cache return side
    logic              ret_valid;
    logic              ret_last;
    logic [DATA_W-1:0] ret_data;
    // AXI AR channel
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    // AXI R channel
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
`ifdef ICACHE_AXI_RD_ERR_EN
    logic              rd_err;
`endif

    modport master (
        input  rd_req, rd_addr, arready, rvalid, rdata, rresp, rlast,
        output rd_rdy, ret_valid, ret_last, ret_data,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
`ifdef ICACHE_AXI_RD_ERR_EN
        , output rd_err
`endif
    );

    modport slave (
        output rd_req, rd_addr, arready, rvalid, rdata, rresp, rlast,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
`ifdef ICACHE_AXI_RD_ERR_EN
        , input rd_err
`endif
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// I-cache line refill: one rd_req becomes one AXI4 INCR burst of BEATS beats, streamed back on ret_*.
// Latency: rd_req edge N -> first ret_valid at N+3 at best (arready at N+1, rvalid at N+2).
// Backpressure: AR stalls until arready; R beats taken whenever rvalid (cache cannot stall); one line in flight.
// Optional ICACHE_AXI_RD_ERR_EN adds sticky rd_err for bad rresp or misplaced rlast.
module icache_axi_rd_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 2,
    parameter int AXI_ID = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    icache_axi_rd_bridge_if.master   bus
);
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_BYTES = BEATS * DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              rready_q;
    logic              ret_valid_q;
    logic              ret_last_q;
    logic [DATA_W-1:0] ret_data_q;
    logic              r_hs;
    logic              final_beat;

    assign r_hs       = bus.rvalid && rready_q;
    assign final_beat = (cnt == CNT_W'(BEATS - 1));

    // Request/burst sequencer; the beat counter alone decides framing, never rlast.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= '0;
        end else begin
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rd_req) begin
                        araddr_q  <= bus.rd_addr & ~ADDR_W'(LINE_BYTES - 1);
                        arvalid_q <= 1'b1;
                        state     <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt       <= '0;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (r_hs) begin
                        ret_data_q  <= bus.rdata;
                        ret_valid_q <= 1'b1;
                        ret_last_q  <= final_beat;
                        cnt         <= cnt + 1'b1;
                        if (final_beat) begin
                            rready_q <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_AXI_RD_ERR_EN
    logic rd_err_q;

    // Sticky error: any beat with a non-OKAY response or rlast out of step with the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_err_q <= 1'b0;
        end else if (state == S_R && r_hs && ((bus.rresp != 2'b00) || (bus.rlast != final_beat))) begin
            rd_err_q <= 1'b1;
        end
    end

    assign bus.rd_err = rd_err_q;
`else
    // Response status and rlast carry no meaning for the cache in this build.
    logic unused_r;
    assign unused_r = ^{bus.rresp, bus.rlast};
`endif

    assign bus.rd_rdy    = (state == S_IDLE);
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arid      = 4'(AXI_ID);
    assign bus.arlen     = 8'(BEATS - 1);
    assign bus.arsize    = 3'($clog2(DATA_W / 8));
    assign bus.arburst   = 2'b01;
    assign bus.rready    = rready_q;
    assign bus.ret_valid = ret_valid_q;
    assign bus.ret_last  = ret_last_q;
    assign bus.ret_data  = ret_data_q;
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge with a transaction-level line model checked every cycle.
// Model counts beats remaining per line; stimulus tasks add literal expectations.
// Build with or without ICACHE_AXI_RD_ERR_EN.
module tb_icache_axi_rd_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BEATS  = 2;
    localparam int LINE   = BEATS * DATA_W / 8;

    logic clock;
    logic rst;
    int   total;
    int   bad;

    icache_axi_rd_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    icache_axi_rd_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BEATS (BEATS),
        .AXI_ID(0)
    ) dut (
        .clock(clock),
        .reset(rst),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line-level model: idle / address outstanding / N beats still to come.
    bit              m_busy;
    bit              m_ar;
    int              m_left;
    logic [31:0]     m_addr;
    logic [63:0]     m_data;
    bit              m_rv;
    bit              m_rl;
    bit              m_err;

    always @(posedge clock) begin
        m_rv = 1'b0;
        m_rl = 1'b0;
        if (rst) begin
            m_busy = 0; m_ar = 0; m_left = 0; m_addr = '0; m_data = '0; m_err = 0;
        end else if (!m_busy) begin
            if (bus.rd_req) begin
                m_busy = 1;
                m_ar   = 1;
                m_addr = bus.rd_addr & ~32'(LINE - 1);
            end
        end else if (m_ar) begin
            if (bus.arready) begin
                m_ar   = 0;
                m_left = BEATS;
            end
        end else if (bus.rvalid) begin
            m_left--;
            m_rv   = 1'b1;
            m_rl   = (m_left == 0);
            m_data = bus.rdata;
            if (bus.rresp != 2'b00 || bus.rlast != m_rl) m_err = 1;
            if (m_left == 0) m_busy = 0;
        end
        #1;
        chk("m_rd_rdy",    bus.rd_rdy,    !m_busy);
        chk("m_arvalid",   bus.arvalid,   m_busy && m_ar);
        chk("m_rready",    bus.rready,    m_busy && !m_ar);
        chk("m_araddr",    bus.araddr,    m_addr);
        chk("m_ret_valid", bus.ret_valid, m_rv);
        chk("m_ret_last",  bus.ret_last,  m_rl);
        chk("m_ret_data",  bus.ret_data,  m_data);
`ifdef ICACHE_AXI_RD_ERR_EN
        chk("m_rd_err",    bus.rd_err,    m_err);
`endif
    end

    // One full line: optional AR stall, optional R gap between beats, response code on the last beat.
    task automatic run_line(input logic [31:0] addr, input logic [31:0] exp_addr, input int ar_wait,
                            input int gap, input logic [1:0] resp_last, input logic [63:0] base);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        bus.arready = 1'b0;
        @(negedge clock);
        bus.rd_req  = 1'b0;
        chk("ar_valid",  bus.arvalid, 1);
        chk("ar_addr",   bus.araddr,  exp_addr);
        chk("ar_len",    bus.arlen,   1);
        chk("ar_size",   bus.arsize,  3);
        chk("ar_burst",  bus.arburst, 1);
        chk("ar_id",     bus.arid,    0);
        chk("busy",      bus.rd_rdy,  0);
        repeat (ar_wait) begin
            @(negedge clock);
            chk("ar_hold_valid", bus.arvalid,   1);
            chk("ar_hold_addr",  bus.araddr,    exp_addr);
            chk("ar_hold_busy",  bus.rd_rdy,    0);
            chk("ar_hold_noret", bus.ret_valid, 0);
        end
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        chk("r_ready", bus.rready,  1);
        chk("ar_drop", bus.arvalid, 0);
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) begin
                bus.rvalid = 1'b0;
                repeat (gap) begin
                    @(negedge clock);
                    chk("gap_noret", bus.ret_valid, 0);
                end
            end
            bus.rvalid = 1'b1;
            bus.rdata  = base * 64'(b + 1);
            bus.rlast  = (b == BEATS - 1);
            bus.rresp  = (b == BEATS - 1) ? resp_last : 2'b00;
            @(negedge clock);
            chk("ret_valid", bus.ret_valid, 1);
            chk("ret_data",  bus.ret_data,  base * 64'(b + 1));
            chk("ret_last",  bus.ret_last,  (b == BEATS - 1));
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        chk("done_rdy", bus.rd_rdy, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst         = 1'b1;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b0;

        // idle after reset
        repeat (10) begin
            @(negedge clock);
            chk("idle_rdy",     bus.rd_rdy,    1);
            chk("idle_arvalid", bus.arvalid,   0);
            chk("idle_rready",  bus.rready,    0);
            chk("idle_ret",     bus.ret_valid, 0);
        end

        // minimum-latency line, data 0x11.. then 0x22..
        run_line(32'h8000_1238, 32'h8000_1230, 0, 0, 2'b00, 64'h1111_1111_1111_1111);
        chk("lit_beat1", bus.ret_data, 64'h2222_2222_2222_2222);
        // AR stalled for 5 cycles
        run_line(32'h0000_0FF4, 32'h0000_0FF0, 5, 0, 2'b00, 64'h0123_4567_0000_0001);
        // R gap of 3 idle cycles between beats
        run_line(32'h1234_567F, 32'h1234_5670, 0, 3, 2'b00, 64'h0A0A_0000_0000_0003);

        // reset in R after beat 0
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h4000_0008;
        @(negedge clock);
        bus.rd_req  = 1'b0;
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 64'h5555_5555_5555_5555;
        @(negedge clock);
        bus.rvalid  = 1'b0;
        chk("rst_pre_ret", bus.ret_valid, 1);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        chk("rst_rdy",    bus.rd_rdy,    1);
        chk("rst_rready", bus.rready,    0);
        chk("rst_ret",    bus.ret_valid, 0);
        chk("rst_ar",     bus.arvalid,   0);
        chk("rst_data",   bus.ret_data,  0);
        run_line(32'h4000_0010, 32'h4000_0010, 0, 0, 2'b00, 64'h0000_0000_7777_0001);

        // SLVERR on the final beat: data/framing unaffected
        run_line(32'hA000_002C, 32'hA000_0020, 0, 1, 2'b10, 64'h0F0F_0F0F_0F0F_0F0F);
`ifdef ICACHE_AXI_RD_ERR_EN
        chk("err_set", bus.rd_err, 1);
        repeat (3) @(negedge clock);
        chk("err_sticky", bus.rd_err, 1);
`endif
        repeat (3) @(negedge clock);
        chk("end_rdy", bus.rd_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end
endmodule
